// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the NOP instruction word, the default reset PC and an alignment helper.
// Optional feature macro used by the fetch unit: FETCH_MISALIGN_CHECK_EN.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STATE_W = 2;

  // Fetch FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE    = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [STATE_W-1:0] ST_HOLD     = 2'd3;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A PC is fetchable only on a 4-byte boundary
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program-counter register with its +4 incrementer (pc_register sub-block).
module instr_fetch_unit_pc_register
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load_i,
  input  logic [31:0] pc_next_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;

  // PC holds its value unless the fetch FSM requests a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (pc_load_i) begin
      pc_q <= pc_next_i;
    end
  end

  assign pc_o       = pc_q;
  // 32-bit add wraps naturally modulo 2^32
  assign pc_plus4_o = pc_q + 32'd4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM towards instruction
// memory plus a one-entry instruction buffer towards decode.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to turn misaligned PCs into
// a faulting NOP instead of a memory request.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic [31:0] PCPlus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic               drop_q, drop_d;
  logic               pc_load_c;
  logic [31:0]        pc_next_c;
  logic [31:0]        pc_cur;
  logic [31:0]        pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic               fault_q, fault_d;
`endif

  instr_fetch_unit_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_load_i  (pc_load_c),
    .pc_next_i  (pc_next_c),
    .pc_o       (pc_cur),
    .pc_plus4_o (pc_plus4)
  );

  // State, request and instruction buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      drop_q     <= drop_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Misaligned-fetch fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  // Next-state, PC update and buffer control
  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    drop_d     = drop_q;
    pc_load_c  = 1'b0;
    pc_next_c  = pc_cur;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d    = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (flush) begin
          pc_load_c = 1'b1;
          pc_next_c = flush_pc;
          // A flush racing the grant leaves a response in flight to drop
          if (imem_gnt && imem_req_q) begin
            state_d = ST_WAIT_RSP;
            drop_d  = 1'b1;
          end
        end else if (imem_gnt && imem_req_q) begin
          state_d = ST_WAIT_RSP;
`ifdef FETCH_MISALIGN_CHECK_EN
        end else if (pc_misaligned(pc_cur)) begin
          state_d    = ST_HOLD;
          if_valid_d = 1'b1;
          if_instr_d = NOP_INSTR;
          if_pc_d    = pc_cur;
          fault_d    = 1'b1;
`endif
        end
      end

      ST_WAIT_RSP: begin
        if (flush) begin
          pc_load_c = 1'b1;
          pc_next_c = flush_pc;
        end
        if (imem_rvalid) begin
          if (drop_q || flush) begin
            // Stale response: discard and refetch from the current PC
            drop_d  = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_cur;
            if_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // Flush takes priority over a simultaneous decode accept
        if (flush || if_ready) begin
          pc_load_c  = 1'b1;
          pc_next_c  = flush ? flush_pc : pc_in;
          if_valid_d = 1'b0;
          state_d    = ST_ISSUE;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (fault_q) begin
            fault_d    = 1'b0;
            if_instr_d = '0;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request is raised for the cycle(s) spent in ISSUE with a fetchable PC
    imem_req_d = (state_d == ST_ISSUE);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (pc_misaligned(pc_load_c ? pc_next_c : pc_cur)) begin
      imem_req_d = 1'b0;
    end
`endif
  end

  assign PCPlus4   = pc_plus4;
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_cur;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC = 0).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic [31:0] PCPlus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int checks;
  int failures;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .PCPlus4     (PCPlus4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    pc_in       = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    if_ready    = 1'b0;

    // Reset values
    repeat (2) step();
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_pcp4",   PCPlus4, 32'h4);
    chk("rst_instr",  if_instr, 32'h0);
    chk("rst_ifpc",   if_pc, 32'h0);
    chk("rst_fault",  {31'd0, fetch_fault}, 32'd0);

    // Release reset; rvalid in the first cycle is ignored (IDLE)
    rst_n = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1;
    imem_rdata = 32'h0050_0093; if_ready = 1'b1; pc_in = 32'h40;
    step();
    chk("issue_req",   {31'd0, imem_req}, 32'd1);
    chk("issue_addr",  imem_addr, 32'h0);
    chk("issue_valid", {31'd0, if_valid}, 32'd0);
    imem_rvalid = 1'b0;
    step();
    chk("wait_req",   {31'd0, imem_req}, 32'd0);
    chk("wait_valid", {31'd0, if_valid}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    step();
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_instr", if_instr, 32'h0050_0093);
    chk("hold_ifpc",  if_pc, 32'h0);
    chk("hold_pcp4",  PCPlus4, 32'h4);

    // Accept with pc_in = 0x40; request waits for grant
    imem_rvalid = 1'b0;
    step();
    chk("acc_req",   {31'd0, imem_req}, 32'd1);
    chk("acc_addr",  imem_addr, 32'h40);
    chk("acc_pcp4",  PCPlus4, 32'h44);
    chk("acc_valid", {31'd0, if_valid}, 32'd0);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nogrant_req",  {31'd0, imem_req}, 32'd1);
      chk("nogrant_addr", imem_addr, 32'h40);
    end
    imem_gnt = 1'b1;
    step();
    chk("grant40_req", {31'd0, imem_req}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_instr", if_instr, 32'h1234_5678);
      chk("stall_ifpc",  if_pc, 32'h40);
      chk("stall_req",   {31'd0, imem_req}, 32'd0);
    end
    if_ready = 1'b1; pc_in = 32'h80;
    step();
    chk("acc80_addr", imem_addr, 32'h80);
    if_ready = 1'b0; imem_gnt = 1'b1;
    step();

    // Flush during WAIT_RSP drops the in-flight response
    imem_gnt = 1'b0; flush = 1'b1; flush_pc = 32'h100;
    step();
    chk("fwait_addr", imem_addr, 32'h100);
    chk("fwait_req",  {31'd0, imem_req}, 32'd0);
    flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("drop_req",   {31'd0, imem_req}, 32'd1);
    chk("drop_addr",  imem_addr, 32'h100);
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    chk("drop_instr", if_instr, 32'h1234_5678);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    step();
    chk("f100_instr", if_instr, 32'h0000_0033);
    chk("f100_ifpc",  if_pc, 32'h100);

    // Flush in HOLD beats a simultaneous if_ready
    imem_rvalid = 1'b0; flush = 1'b1; flush_pc = 32'h200;
    if_ready = 1'b1; pc_in = 32'h300;
    step();
    chk("fhold_valid", {31'd0, if_valid}, 32'd0);
    chk("fhold_addr",  imem_addr, 32'h200);
    chk("fhold_req",   {31'd0, imem_req}, 32'd1);

    // Flush in ISSUE before grant; PC wrap at the top of memory
    if_ready = 1'b0; flush_pc = 32'hFFFF_FFFC;
    step();
    chk("fiss_addr", imem_addr, 32'hFFFF_FFFC);
    chk("fiss_pcp4", PCPlus4, 32'h0000_0000);
    chk("fiss_req",  {31'd0, imem_req}, 32'd1);
    flush = 1'b0; imem_gnt = 1'b1;
    step();

    // Flush coincident with rvalid discards that response
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    flush = 1'b1; flush_pc = 32'h20;
    step();
    chk("frv_addr",  imem_addr, 32'h20);
    chk("frv_req",   {31'd0, imem_req}, 32'd1);
    chk("frv_valid", {31'd0, if_valid}, 32'd0);
    chk("frv_instr", if_instr, 32'h0000_0033);
    imem_rvalid = 1'b0; flush = 1'b0; imem_gnt = 1'b1;
    step();

    // Reset mid-transaction
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_req",   {31'd0, imem_req}, 32'd0);
    chk("mrst_addr",  imem_addr, 32'h0);
    chk("mrst_valid", {31'd0, if_valid}, 32'd0);
    chk("mrst_instr", if_instr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055; imem_gnt = 1'b1;
    step();
    chk("mrel_valid", {31'd0, if_valid}, 32'd0);
    chk("mrel_req",   {31'd0, imem_req}, 32'd1);
    imem_rvalid = 1'b0;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    chk("mrel_instr", if_instr, 32'h0050_0093);
    chk("mrel_ifpc",  if_pc, 32'h0);

    // Accept with a misaligned next PC
    imem_rvalid = 1'b0; if_ready = 1'b1; pc_in = 32'h42;
    step();
    if_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_req0", {31'd0, imem_req}, 32'd0);
    step();
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_instr", if_instr, 32'h0000_0013);
    chk("mis_ifpc",  if_pc, 32'h42);
    chk("mis_req1",  {31'd0, imem_req}, 32'd0);
    if_ready = 1'b1; pc_in = 32'h8;
    step();
    chk("mis_clr_fault", {31'd0, fetch_fault}, 32'd0);
    chk("mis_clr_valid", {31'd0, if_valid}, 32'd0);
    chk("mis_clr_req",   {31'd0, imem_req}, 32'd1);
    chk("mis_clr_addr",  imem_addr, 32'h8);
    if_ready = 1'b0;
`else
    chk("mis_req",   {31'd0, imem_req}, 32'd1);
    chk("mis_addr",  imem_addr, 32'h42);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pc_in  input  32  next-PC value from the PC-selection mux.
REQ-005 PCPlus4  output  32  current PC + 4, fed back to the PC-selection mux.
REQ-006 imem_req  output  1  instruction-memory request valid.
REQ-007 imem_addr  output  32  instruction-memory byte address; equals current PC.
REQ-008 imem_gnt  input  1  memory accepted the request this cycle.
REQ-009 imem_rvalid  input  1  read data valid, one pulse per granted request.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 flush  input  1  one-cycle pulse: discard the current fetch and restart at flush_pc.
REQ-012 flush_pc  input  32  restart address, sampled when flush=1.
REQ-013 if_valid  output  1  instruction available to decode.
REQ-014 if_ready  input  1  decode accepts the instruction.
REQ-015 if_instr  output  32  held instruction word.
REQ-016 if_pc  output  32  address of if_instr.
REQ-017 fetch_fault  output  1  misaligned-PC flag (see Configuration).

Function
REQ-018 States are IDLE, ISSUE, WAIT_RSP and HOLD; after reset the state is IDLE.
REQ-019 IDLE goes to ISSUE unconditionally on the next cycle.
REQ-020 In ISSUE, imem_req=1 with imem_addr=PC; imem_req and imem_addr stay stable until imem_gnt=1, then the state goes to WAIT_RSP.
REQ-021 In WAIT_RSP, imem_rvalid=1 latches imem_rdata into if_instr and PC into if_pc, then the state goes to HOLD; at most one request is outstanding.
REQ-022 In HOLD, if_valid=1 and if_instr/if_pc stay stable until if_ready=1.
REQ-023 If if_valid=1 and if_ready=1, PC takes pc_in and the state goes to ISSUE, so the next request leaves one cycle after acceptance.
REQ-024 PCPlus4 is combinational PC+4 with modulo-2^32 wrap (32'hFFFF_FFFC gives 32'h0000_0000).
REQ-025 flush in ISSUE before the grant: PC takes flush_pc and the state stays ISSUE; a flush in the same cycle as imem_gnt is treated as a flush in WAIT_RSP.
REQ-026 flush in WAIT_RSP: PC takes flush_pc and a drop flag is set; the matching imem_rvalid is discarded (drop cleared, state goes to ISSUE). A flush in the same cycle as imem_rvalid also discards that response.
REQ-027 flush in HOLD: if_valid falls the next cycle, PC takes flush_pc and the state goes to ISSUE; flush overrides a simultaneous if_ready.
REQ-028 Latency: with imem_gnt tied high and imem_rvalid one cycle after the grant, if_valid rises 2 cycles after entering ISSUE.

Reset
REQ-029 While rst_n=0: PC=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=0, drop=0, fetch_fault=0; imem_addr=RESET_PC and PCPlus4=RESET_PC+4 follow from PC.
REQ-030 Reset asserted mid-transaction abandons the outstanding request; any imem_rvalid in the first cycle after deassertion is ignored.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN defined: when PC[1:0]!=0 in ISSUE, no request is issued; the block goes to HOLD with fetch_fault=1, if_valid=1 and if_instr=32'h0000_0013 (NOP); fault and NOP clear when that HOLD entry is accepted or flushed.
REQ-032 Macro FETCH_MISALIGN_CHECK_EN undefined: fetch_fault is tied to 0 and PC[1:0] is passed to imem_addr unchecked.

Structure
REQ-033 A shared package holds the fetch-state enumeration, NOP encoding 32'h0000_0013 and the default RESET_PC constant.
REQ-034 The PC register with its +4 adder forms one natural sub-module, pc_register; the FSM and instruction buffer stay in instr_fetch_unit.

Verification
REQ-035 Reset release with RESET_PC=0, gnt=1, rvalid one cycle later, instr=32'h00500093, if_ready=1 -> if_pc=0, if_instr=32'h00500093, PCPlus4=4.
REQ-036 pc_in=32'h0000_0040 at acceptance -> next imem_addr=32'h40 and imem_req stays high until the grant.
REQ-037 if_ready=0 for 5 cycles -> if_valid held, if_instr/if_pc unchanged, no new imem_req.
REQ-038 flush with flush_pc=32'h100 during WAIT_RSP -> stale rvalid data never appears on if_instr; next imem_addr=32'h100.
REQ-039 PC=32'hFFFF_FFFC -> PCPlus4=32'h0000_0000.
REQ-040 FETCH_MISALIGN_CHECK_EN defined, pc_in=32'h0000_0042 -> no imem_req, fetch_fault=1, if_instr=32'h0000_0013.
